converter_sequencer: RTL and testbench

//   Start-up, run and shutdown sequencer for the full-bridge resonant converter.

---
 rtl/converter_sequencer.sv | 146 ++++++++++++++
 tb/tb_converter_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/converter_sequencer.sv
// Start-up/run/shutdown sequencer for the full-bridge resonant converter gate drive.
// Latency: every output is registered; gates follow i_mosfet one clock later in RUN.
// No backpressure: i_enable and faults act on the next edge, async reset clears outputs at once.
module converter_sequencer #(
    parameter int BOOT_CYCLES = 1000,
    parameter int PRE_CYCLES  = 400,
    parameter int RAMP_DIV    = 100000,
    parameter int PHI_START   = 0,
    parameter int PHI_MAX     = 70,
    parameter int IC_LIMIT    = 7000,
    parameter int OC_FILTER   = 8
) (
    input  logic        i_clock,
    input  logic        i_RESET,
    input  logic        i_enable,
    input  logic [3:0]  i_mosfet,
    input  logic [13:0] i_iC,
    input  logic [7:0]  i_phi_target,
    output logic [3:0]  o_Q,
    output logic [7:0]  o_phi,
    output logic        o_ctrl_rst_n,
    output logic [2:0]  o_state,
    output logic [1:0]  o_fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BOOT  = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam int SEQ_MAX = (BOOT_CYCLES > PRE_CYCLES) ? BOOT_CYCLES : PRE_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int RAMP_W  = $clog2(RAMP_DIV + 1);
    localparam int OC_W    = $clog2(OC_FILTER + 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [SEQ_W-1:0]  seq_cnt;
    logic [RAMP_W-1:0] ramp_cnt;
    logic [OC_W-1:0]   oc_cnt;

    logic [14:0] ic_ext;
    logic [14:0] ic_abs;
    logic        oc_over;
    logic        oc_zone;
    logic        oc_trip;
    logic        st_hit;
    logic        st_trip;
    logic [7:0]  phi_tgt;
    logic        seq_done;

    // 15-bit magnitude so the most negative sample (-8192) is not misread
    assign ic_ext  = {i_iC[13], i_iC};
    assign ic_abs  = i_iC[13] ? (~ic_ext + 15'd1) : ic_ext;
    assign oc_over = ic_abs > 15'(IC_LIMIT);
    assign oc_zone = (state == S_PRE) || (state == S_RUN);
    assign oc_trip = oc_zone && oc_over && (oc_cnt == OC_W'(OC_FILTER - 1));

    assign st_hit  = (i_mosfet[0] & i_mosfet[2]) | (i_mosfet[1] & i_mosfet[3]);
    assign st_trip = (state == S_RUN) && st_hit;

    assign phi_tgt  = (i_phi_target > 8'(PHI_MAX)) ? 8'(PHI_MAX) : i_phi_target;
    assign seq_done = ((state == S_BOOT) && (seq_cnt == SEQ_W'(BOOT_CYCLES - 1))) ||
                      ((state == S_PRE)  && (seq_cnt == SEQ_W'(PRE_CYCLES - 1)));

    assign o_state = state;

    // Faults win over a simultaneous disable so the cause is still latched for diagnosis
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_enable) state_nxt = S_BOOT;
            S_BOOT: begin
                if (!i_enable)     state_nxt = S_IDLE;
                else if (seq_done) state_nxt = S_PRE;
            end
            S_PRE: begin
                if (oc_trip)       state_nxt = S_FAULT;
                else if (!i_enable) state_nxt = S_IDLE;
                else if (seq_done) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (st_trip || oc_trip) state_nxt = S_FAULT;
                else if (!i_enable)     state_nxt = S_IDLE;
            end
            S_FAULT: if (!i_enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state        <= S_IDLE;
            seq_cnt      <= '0;
            ramp_cnt     <= '0;
            oc_cnt       <= '0;
            o_Q          <= 4'b0000;
            o_phi        <= 8'(PHI_START);
            o_ctrl_rst_n <= 1'b0;
            o_fault      <= 2'b00;
        end else begin
            state <= state_nxt;

            if ((state_nxt == state) && ((state == S_BOOT) || (state == S_PRE)))
                seq_cnt <= seq_cnt + SEQ_W'(1);
            else
                seq_cnt <= '0;

            if (oc_zone && oc_over && !oc_trip)
                oc_cnt <= oc_cnt + OC_W'(1);
            else
                oc_cnt <= '0;

            if ((state == S_IDLE) && (state_nxt == S_BOOT))
                o_fault <= 2'b00;
            else if ((state != S_FAULT) && (state_nxt == S_FAULT))
                o_fault <= st_trip ? 2'b01 : 2'b10;

            // Gate pattern is chosen from the destination state, so no illegal pattern is ever driven
            case (state_nxt)
                S_BOOT:  o_Q <= 4'b1100;
                S_PRE:   o_Q <= 4'b1001;
                S_RUN:   o_Q <= st_hit ? 4'b0000 : i_mosfet;
                default: o_Q <= 4'b0000;
            endcase
            o_ctrl_rst_n <= (state_nxt == S_RUN);

            if ((state == S_PRE) && (state_nxt == S_RUN)) begin
                o_phi    <= 8'(PHI_START);
                ramp_cnt <= '0;
            end else if (state == S_RUN) begin
                if (ramp_cnt == RAMP_W'(RAMP_DIV - 1)) begin
                    ramp_cnt <= '0;
                    if (o_phi < phi_tgt)
                        o_phi <= o_phi + 8'd1;
                    else if (o_phi > phi_tgt)
                        o_phi <= o_phi - 8'd1;
                end else begin
                    ramp_cnt <= ramp_cnt + RAMP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_converter_sequencer.sv
// Bench for converter_sequencer: directed vector table, async-reset sequence, then random run vs. reference model.
module tb_converter_sequencer;

    localparam int BOOT_CYCLES = 1000;
    localparam int PRE_CYCLES  = 400;
    localparam int RAMP_DIV    = 10;
    localparam int PHI_START   = 0;
    localparam int PHI_MAX     = 70;
    localparam int IC_LIMIT    = 7000;
    localparam int OC_FILTER   = 8;

    localparam int S_IDLE = 0, S_BOOT = 1, S_PRE = 2, S_RUN = 3, S_FLT = 4;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [3:0]         mos;
    logic signed [13:0] ic;
    logic [7:0]         tgt;
    logic [3:0]         q;
    logic [7:0]         phi;
    logic               ctrl_rst_n;
    logic [2:0]         state;
    logic [1:0]         fault;

    int n_chk = 0;
    int n_err = 0;

    converter_sequencer #(
        .BOOT_CYCLES(BOOT_CYCLES), .PRE_CYCLES(PRE_CYCLES), .RAMP_DIV(RAMP_DIV),
        .PHI_START(PHI_START), .PHI_MAX(PHI_MAX), .IC_LIMIT(IC_LIMIT), .OC_FILTER(OC_FILTER)
    ) dut (
        .i_clock(clk),
        .i_RESET(rst_n),
        .i_enable(en),
        .i_mosfet(mos),
        .i_iC(ic),
        .i_phi_target(tgt),
        .o_Q(q),
        .o_phi(phi),
        .o_ctrl_rst_n(ctrl_rst_n),
        .o_state(state),
        .o_fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode, time spent in mode, over-current run length, phi ramp
    int         m_st, m_t, m_oc, m_ramp, m_phi, m_fault;
    logic [3:0] m_q;
    logic       m_rst;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_t = 0; m_oc = 0; m_ramp = 0;
        m_phi = PHI_START; m_fault = 0; m_q = 4'b0000; m_rst = 1'b0;
    endtask

    task automatic model_step();
        int  ns, goal, mag, run;
        bit  st, over, zone;
        goal = (int'(tgt) > PHI_MAX) ? PHI_MAX : int'(tgt);
        mag  = (int'(ic) < 0) ? -int'(ic) : int'(ic);
        over = mag > IC_LIMIT;
        st   = (mos[0] && mos[2]) || (mos[1] && mos[3]);
        zone = (m_st == S_PRE) || (m_st == S_RUN);
        run  = (zone && over) ? m_oc + 1 : 0;
        ns   = m_st;
        if (m_st == S_RUN && st) begin
            ns = S_FLT; m_fault = 1;
        end else if (zone && run >= OC_FILTER) begin
            ns = S_FLT; m_fault = 2;
        end else if (!en) begin
            ns = S_IDLE;
        end else if (m_st == S_IDLE) begin
            ns = S_BOOT; m_fault = 0;
        end else if (m_st == S_BOOT && m_t + 1 == BOOT_CYCLES) begin
            ns = S_PRE;
        end else if (m_st == S_PRE && m_t + 1 == PRE_CYCLES) begin
            ns = S_RUN;
        end
        if (m_st == S_RUN) begin
            m_ramp++;
            if (m_ramp == RAMP_DIV) begin
                m_ramp = 0;
                if (m_phi < goal) m_phi++;
                else if (m_phi > goal) m_phi--;
            end
        end
        if (m_st == S_PRE && ns == S_RUN) begin
            m_phi = PHI_START; m_ramp = 0;
        end
        case (ns)
            S_BOOT:  m_q = 4'b1100;
            S_PRE:   m_q = 4'b1001;
            S_RUN:   m_q = st ? 4'b0000 : mos;
            default: m_q = 4'b0000;
        endcase
        m_rst = (ns == S_RUN);
        m_t   = (ns == m_st) ? m_t + 1 : 0;
        m_oc  = run;
        m_st  = ns;
    endtask

    task automatic cmp_model();
        chk("model.state", int'(state), m_st);
        chk("model.q", int'(q), int'(m_q));
        chk("model.phi", int'(phi), m_phi);
        chk("model.fault", int'(fault), m_fault);
        chk("model.ctrl_rst_n", int'(ctrl_rst_n), int'(m_rst));
        if ((q[0] && q[2]) || (q[1] && q[3])) chk("leg_overlap", int'(q), 0);
    endtask

    // Inputs are set at a negedge; the model advances for the coming posedge, outputs sampled next negedge
    task automatic tick();
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    typedef struct {
        string      name;
        bit         en;
        logic [3:0] mos;
        int         ic;
        int         tgt;
        int         n;
        int         st;
        logic [3:0] q;
        int         phi;
        int         fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, bit e, logic [3:0] m, int i, int t, int n,
                                int s, logic [3:0] qq, int p, int f);
        vec_t v;
        v.name = nm; v.en = e; v.mos = m; v.ic = i; v.tgt = t; v.n = n;
        v.st = s; v.q = qq; v.phi = p; v.fault = f;
        return v;
    endfunction

    initial begin
        int         burst;
        int         cur_t;
        logic [3:0] r;

        vecs.push_back(mk("boot_enter",   1, 4'b0000,     0, 20,    1, 1, 4'b1100,  0, 0));
        vecs.push_back(mk("boot_last",    1, 4'b0000,     0, 20,  999, 1, 4'b1100,  0, 0));
        vecs.push_back(mk("pre_enter",    1, 4'b0000,     0, 20,    1, 2, 4'b1001,  0, 0));
        vecs.push_back(mk("pre_last",     1, 4'b0000,     0, 20,  399, 2, 4'b1001,  0, 0));
        vecs.push_back(mk("run_enter",    1, 4'b0110,     0, 20,    1, 3, 4'b0110,  0, 0));
        vecs.push_back(mk("run_track",    1, 4'b1001,     0, 20,    1, 3, 4'b1001,  0, 0));
        vecs.push_back(mk("ramp_up20",    1, 4'b1001,     0, 20,  200, 3, 4'b1001, 20, 0));
        vecs.push_back(mk("ramp_dn15",    1, 4'b1001,     0, 15,   50, 3, 4'b1001, 15, 0));
        vecs.push_back(mk("ramp_hold",    1, 4'b1001,     0, 15,   30, 3, 4'b1001, 15, 0));
        vecs.push_back(mk("shoot_thru",   1, 4'b0101,     0, 15,    1, 4, 4'b0000, 15, 1));
        vecs.push_back(mk("fault_hold",   1, 4'b0000,     0, 15,    5, 4, 4'b0000, 15, 1));
        vecs.push_back(mk("fault_exit",   0, 4'b0000,     0, 15,    1, 0, 4'b0000, 15, 1));
        vecs.push_back(mk("reenable",     1, 4'b0000,     0, 15,    1, 1, 4'b1100, 15, 0));
        vecs.push_back(mk("boot_mid",     1, 4'b0000,     0, 15,  499, 1, 4'b1100, 15, 0));
        vecs.push_back(mk("boot_abort",   0, 4'b0000,     0, 15,    1, 0, 4'b0000, 15, 0));
        vecs.push_back(mk("boot_full",    1, 4'b0000,     0, 15, 1000, 1, 4'b1100, 15, 0));
        vecs.push_back(mk("pre_again",    1, 4'b0000,     0, 15,    1, 2, 4'b1001, 15, 0));
        vecs.push_back(mk("oc_7_cycles",  1, 4'b0000, -7500, 15,    7, 2, 4'b1001, 15, 0));
        vecs.push_back(mk("oc_clear",     1, 4'b0000,     0, 15,    1, 2, 4'b1001, 15, 0));
        vecs.push_back(mk("oc_7_again",   1, 4'b0000, -7500, 15,    7, 2, 4'b1001, 15, 0));
        vecs.push_back(mk("oc_8th_trip",  1, 4'b0000, -7500, 15,    1, 4, 4'b0000, 15, 2));
        vecs.push_back(mk("oc_exit",      0, 4'b0000,     0, 15,    1, 0, 4'b0000, 15, 2));
        vecs.push_back(mk("ic_at_limit",  1, 4'b0110,  7000, 15, 1401, 3, 4'b0110,  0, 0));
        vecs.push_back(mk("ic_min_trip",  1, 4'b0110, -8192, 15,    8, 4, 4'b0000,  0, 2));
        vecs.push_back(mk("final_idle",   0, 4'b0000,     0, 15,    1, 0, 4'b0000,  0, 2));

        en = 1'b0; mos = 4'b0000; ic = '0; tgt = 8'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.state", int'(state), S_IDLE);
        chk("reset.q", int'(q), 0);
        chk("reset.phi", int'(phi), PHI_START);
        chk("reset.ctrl_rst_n", int'(ctrl_rst_n), 0);
        chk("reset.fault", int'(fault), 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            en = vecs[k].en; mos = vecs[k].mos; ic = 14'(vecs[k].ic); tgt = 8'(vecs[k].tgt);
            repeat (vecs[k].n) tick();
            chk({vecs[k].name, ".state"}, int'(state), vecs[k].st);
            chk({vecs[k].name, ".q"}, int'(q), int'(vecs[k].q));
            chk({vecs[k].name, ".phi"}, int'(phi), vecs[k].phi);
            chk({vecs[k].name, ".fault"}, int'(fault), vecs[k].fault);
            chk({vecs[k].name, ".ctrl_rst_n"}, int'(ctrl_rst_n), (vecs[k].st == S_RUN) ? 1 : 0);
        end

        // Asynchronous reset in the middle of RUN must clear the bridge before any clock edge
        en = 1'b1; mos = 4'b1001; ic = '0; tgt = 8'd30;
        repeat (1431) tick();
        chk("arst.pre_state", int'(state), S_RUN);
        chk("arst.pre_rst_n", int'(ctrl_rst_n), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.q", int'(q), 0);
        chk("arst.ctrl_rst_n", int'(ctrl_rst_n), 0);
        chk("arst.state", int'(state), S_IDLE);
        chk("arst.phi", int'(phi), PHI_START);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Random phase; phi target occasionally above the clamp
        burst = 0;
        for (int c = 0; c < 25000; c++) begin
            if (m_st == S_FLT) en = ($urandom_range(0, 19) != 0);
            else               en = ($urandom_range(0, 2999) != 0);
            if (burst > 0) begin
                burst--;
                if ($urandom_range(0, 1) == 1) ic = 14'(-int'($urandom_range(7001, 8192)));
                else                           ic = 14'(int'($urandom_range(7001, 8191)));
            end else begin
                if ($urandom_range(0, 299) == 0) burst = int'($urandom_range(1, 10));
                ic = 14'(int'($urandom_range(0, 14000)) - 7000);
            end
            r = 4'($urandom_range(0, 15));
            if (((r[0] & r[2]) | (r[1] & r[3])) && ($urandom_range(0, 199) != 0)) r = r & 4'b0011;
            mos = r;
            if ($urandom_range(0, 1999) == 0) begin
                cur_t = int'($urandom_range(0, 255));
                tgt = 8'(cur_t);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
